ika2151_timer_ctrl: RTL and testbench
=====================================

# ika2151_timer_ctrl

Timer scheduler for the OPM core: sequences two load/count/overflow counters (Timer A, 10-bit; Timer B, 8-bit with a fixed prescaler) from the per-sample tick. It turns overflows into status flags, an IRQ line and a CSM key-on pulse. It sits between the register file (timer values, control bits) and the bus interface / envelope key-on logic, and replaces ad-hoc wiring of counter cells with one controlled block.

## Interface
- TA_WIDTH, 10, Timer A counter/preload width
- TB_WIDTH, 8, Timer B counter/preload width
- TB_PRESCALE, 16, sample ticks per Timer B count; power of two, ≥ 2
- i_EMUCLK  in  1  master clock; all state changes on its rising edge
- i_RST  in  1  asynchronous, active-high reset
- i_PCEN_n  in  1  phi1 positive-edge enable, active low; state advances only when low
- i_SAMPLE_TICK  in  1  one-enable-cycle pulse per output sample
- i_TA_VAL  in  TA_WIDTH  Timer A preload value
- i_TB_VAL  in  TB_WIDTH  Timer B preload value
- i_TA_LOAD, i_TB_LOAD  in  1 each  run-enable level per timer
- i_TA_IRQEN, i_TB_IRQEN  in  1 each  flag-set enable per timer
- i_TA_FRST, i_TB_FRST  in  1 each  flag-clear pulses
- i_CSM_EN  in  1  CSM mode enable
- o_TA_CNT  out  TA_WIDTH  Timer A counter
- o_TB_CNT  out  TB_WIDTH  Timer B counter
- o_TA_FLAG, o_TB_FLAG  out  1 each  sticky overflow flags
- o_IRQ_n  out  1  active-low interrupt
- o_CSM_KON  out  1  key-on-all pulse, one enable cycle

## Operation
- An "enable cycle" is an i_EMUCLK rising edge with i_PCEN_n = 0. All registers hold on other edges.
- Each timer has a 2-state FSM: IDLE and RUN.
- **IDLE → RUN:** on the enable cycle where LOAD = 1 and the previous sampled LOAD = 0 (rising edge detected on enable cycles). The counter is preloaded with VAL in that same cycle.
  - For Timer B, the prescaler is also cleared to 0.
- **RUN → IDLE:** on the enable cycle with LOAD = 0. The counter holds its value and does not reload.
- **Timer A in RUN:** on i_SAMPLE_TICK, the counter increments.
  - At 2^TA_WIDTH−1 the counter instead reloads i_TA_VAL (the current value, not the value latched at start), raising an A overflow.
- **Timer B in RUN:** on i_SAMPLE_TICK, the prescaler increments modulo TB_PRESCALE.
  - When a tick arrives with the prescaler at TB_PRESCALE−1, the counter increments, or reloads at 2^TB_WIDTH−1 with a B overflow.
- **Flags:**
  - An overflow with IRQEN = 1 sets FLAG; with IRQEN = 0 the flag is not set.
  - FRST clears FLAG, and wins over a simultaneous set.
  - Clearing IRQEN does not clear an already-set FLAG.
- **IRQ:** o_IRQ_n = ~(o_TA_FLAG | o_TB_FLAG), registered.
- **CSM:** o_CSM_KON = 1 for exactly the enable cycle following an A overflow when i_CSM_EN = 1. IRQEN has no effect on it.
- **Load edge and tick together:** a LOAD rising edge coinciding with a tick preloads only; that tick is not counted.
- **Preload at max:** if VAL = max, every tick overflows, giving a period of 1 count.

## Timing
- **Reset values:** both FSMs IDLE, counters 0, prescaler 0, LOAD history 0, flags 0, o_IRQ_n = 1, o_CSM_KON = 0.
- Reset is asynchronous and overrides everything. Asserting it mid-count returns all state to the reset values immediately. After release, a LOAD that is still high counts as a new rising edge.
- **Counter latency:** the new counter value is visible after the enable cycle that samples the tick.
- **Flag latency:** FLAG is visible after the same enable cycle as the overflow. o_IRQ_n follows one enable cycle later.
- **CSM latency:** o_CSM_KON is high during the enable cycle after the overflow cycle and low again afterwards.
- **Timer A period:** (2^TA_WIDTH − VAL) ticks.
- **Timer B period:** TB_PRESCALE × (2^TB_WIDTH − VAL) ticks, with the first count after TB_PRESCALE ticks from start.

## Test plan
- **Reset:** assert i_RST asynchronously with no clock → all outputs at reset values; o_IRQ_n = 1.
- **Timer A period:** TA_VAL = 1020, IRQEN = 1, LOAD rises, tick every 4 enable cycles → count 1020, 1021, 1022, 1023, then reload 1020; flag set after 4th tick; o_IRQ_n low one enable cycle later; repeats every 4 ticks.
- **Timer B period:** TB_VAL = 254, prescale 16, IRQEN = 1 → o_TB_CNT = 255 after 16 ticks; overflow and flag after 32 ticks; counter back to 254.
- **Flag control:**
  - IRQEN = 0 during an overflow → flag stays 0, reload still occurs.
  - FRST in the same cycle as an overflow → flag stays 0.
  - FRST alone → flag clears and o_IRQ_n returns high one enable cycle later.
- **CSM and stop:** CSM_EN = 1, TA_VAL = 1023 → o_CSM_KON pulses once per tick, each pulse 1 enable cycle wide. Drop LOAD → counter freezes and no further pulses. Raise LOAD again → counter preloads 1023.
- **Reset mid-count and gating:** assert i_RST with o_TB_CNT = 200 and prescaler = 7 → immediate zeroing. Also: ticks arriving with i_PCEN_n = 1 are ignored.

Source files
------------

// File: rtl/ika2151_timer_ctrl.sv
// ---------------------------------------------------------------------------
// ika2151_timer_ctrl
//
// Timer scheduler for the OPM core. Runs Timer A (TA_WIDTH-bit up-counter)
// and Timer B (TB_WIDTH-bit up-counter behind a TB_PRESCALE prescaler) from
// the per-sample tick. Counter overflows become sticky status flags, an
// active-low IRQ and a one-enable-cycle CSM key-on pulse.
//
// Ports
//   i_EMUCLK        master clock, all state changes on its rising edge
//   i_RST           asynchronous active-high reset
//   i_PCEN_n        phi1 enable, active low; state advances only when low
//   i_SAMPLE_TICK   one-enable-cycle pulse per output sample
//   i_TA_VAL        Timer A preload value (also the live reload value)
//   i_TB_VAL        Timer B preload value (also the live reload value)
//   i_TA_LOAD       Timer A run-enable level; rising edge starts the timer
//   i_TB_LOAD       Timer B run-enable level; rising edge starts the timer
//   i_TA_IRQEN      allow Timer A overflow to set o_TA_FLAG
//   i_TB_IRQEN      allow Timer B overflow to set o_TB_FLAG
//   i_TA_FRST       clear o_TA_FLAG (beats a simultaneous set)
//   i_TB_FRST       clear o_TB_FLAG (beats a simultaneous set)
//   i_CSM_EN        CSM mode: Timer A overflow keys on all channels
//   o_TA_CNT        Timer A counter
//   o_TB_CNT        Timer B counter
//   o_TA_FLAG       sticky Timer A overflow flag
//   o_TB_FLAG       sticky Timer B overflow flag
//   o_IRQ_n         registered ~(o_TA_FLAG | o_TB_FLAG)
//   o_CSM_KON       key-on-all pulse for the enable cycle after an A overflow
// ---------------------------------------------------------------------------
module ika2151_timer_ctrl #(
  parameter int TA_WIDTH    = 10,
  parameter int TB_WIDTH    = 8,
  parameter int TB_PRESCALE = 16   // power of two, >= 2
) (
  input  logic                i_EMUCLK,
  input  logic                i_RST,
  input  logic                i_PCEN_n,
  input  logic                i_SAMPLE_TICK,
  input  logic [TA_WIDTH-1:0] i_TA_VAL,
  input  logic [TB_WIDTH-1:0] i_TB_VAL,
  input  logic                i_TA_LOAD,
  input  logic                i_TB_LOAD,
  input  logic                i_TA_IRQEN,
  input  logic                i_TB_IRQEN,
  input  logic                i_TA_FRST,
  input  logic                i_TB_FRST,
  input  logic                i_CSM_EN,
  output logic [TA_WIDTH-1:0] o_TA_CNT,
  output logic [TB_WIDTH-1:0] o_TB_CNT,
  output logic                o_TA_FLAG,
  output logic                o_TB_FLAG,
  output logic                o_IRQ_n,
  output logic                o_CSM_KON
);

  localparam int PRE_W = $clog2(TB_PRESCALE);

  // All-ones constants: counter terminal values and the last prescaler phase.
  // The prescaler is a power of two, so its last phase is all ones and its
  // increment wraps to zero without an explicit compare-and-clear.
  localparam logic [TA_WIDTH-1:0] TA_MAX   = '1;
  localparam logic [TB_WIDTH-1:0] TB_MAX   = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tmr_state_e;

  // Enable-cycle qualifier: every register below only moves when this is 1.
  logic pcen;
  assign pcen = ~i_PCEN_n;

  // -------------------------------------------------------------------------
  // Timer A
  // -------------------------------------------------------------------------
  tmr_state_e ta_state;
  logic       ta_load_q;   // LOAD as sampled on the previous enable cycle
  logic       ta_rise;     // LOAD rising edge: start and preload
  logic       ta_step;     // tick counted this enable cycle
  logic       ta_ovf;      // counted tick lands on the terminal value

  // A rising LOAD edge always wins over a coincident tick: that tick only
  // preloads and is not counted.
  assign ta_rise = i_TA_LOAD & ~ta_load_q;
  assign ta_step = (ta_state == ST_RUN) & i_TA_LOAD & i_SAMPLE_TICK & ~ta_rise;
  assign ta_ovf  = ta_step & (o_TA_CNT == TA_MAX);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours regardless of the
  // order the statements are written in.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      ta_state  <= ST_IDLE;
      ta_load_q <= 1'b0;
      o_TA_CNT  <= '0;
    end else if (pcen) begin
      ta_load_q <= i_TA_LOAD;
      if (ta_rise) begin
        ta_state <= ST_RUN;
        o_TA_CNT <= i_TA_VAL;
      end else if (!i_TA_LOAD) begin
        // Stopping freezes the counter where it is.
        ta_state <= ST_IDLE;
      end else if (ta_step) begin
        // Reload uses the live i_TA_VAL, not a copy captured at start.
        o_TA_CNT <= ta_ovf ? i_TA_VAL : o_TA_CNT + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Timer B
  // -------------------------------------------------------------------------
  tmr_state_e       ta_unused_state_guard;   // keeps enum use symmetric
  tmr_state_e       tb_state;
  logic             tb_load_q;
  logic             tb_rise;
  logic             tb_step;   // tick advances the prescaler
  logic             tb_carry;  // prescaler wraps: counter advances
  logic             tb_ovf;
  logic [PRE_W-1:0] tb_pre;

  assign ta_unused_state_guard = ST_IDLE;

  assign tb_rise  = i_TB_LOAD & ~tb_load_q;
  assign tb_step  = (tb_state == ST_RUN) & i_TB_LOAD & i_SAMPLE_TICK & ~tb_rise;
  assign tb_carry = tb_step & (tb_pre == PRE_LAST);
  assign tb_ovf   = tb_carry & (o_TB_CNT == TB_MAX);

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      tb_state  <= ST_IDLE;
      tb_load_q <= 1'b0;
      tb_pre    <= '0;
      o_TB_CNT  <= '0;
    end else if (pcen) begin
      tb_load_q <= i_TB_LOAD;
      if (tb_rise) begin
        // Clearing the prescaler makes the first count land exactly
        // TB_PRESCALE ticks after start.
        tb_state <= ST_RUN;
        tb_pre   <= '0;
        o_TB_CNT <= i_TB_VAL;
      end else if (!i_TB_LOAD) begin
        tb_state <= ST_IDLE;
      end else if (tb_step) begin
        tb_pre <= tb_pre + 1'b1;
        if (tb_carry) begin
          o_TB_CNT <= tb_ovf ? i_TB_VAL : o_TB_CNT + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Flags, IRQ and CSM key-on
  // -------------------------------------------------------------------------
  // Flags become visible right after the overflow enable cycle. o_IRQ_n is
  // built from the registered flags, so it trails them by one enable cycle.
  // CSM ignores IRQEN: it keys on from the raw A overflow.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      o_TA_FLAG <= 1'b0;
      o_TB_FLAG <= 1'b0;
      o_IRQ_n   <= 1'b1;
      o_CSM_KON <= 1'b0;
    end else if (pcen) begin
      // Flag reset takes priority over a coincident set.
      if (i_TA_FRST)                o_TA_FLAG <= 1'b0;
      else if (ta_ovf & i_TA_IRQEN) o_TA_FLAG <= 1'b1;

      if (i_TB_FRST)                o_TB_FLAG <= 1'b0;
      else if (tb_ovf & i_TB_IRQEN) o_TB_FLAG <= 1'b1;

      o_IRQ_n   <= ~(o_TA_FLAG | o_TB_FLAG);
      o_CSM_KON <= ta_ovf & i_CSM_EN;
    end
  end

endmodule

// File: tb/tb_ika2151_timer_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for ika2151_timer_ctrl. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when the DUT output is
// sampled, one clock-to-output delay after the rising edge.
// ---------------------------------------------------------------------------
module tb_ika2151_timer_ctrl;

  localparam int TA_W = 10;
  localparam int TB_W = 8;
  localparam int PRE  = 16;

  logic            i_EMUCLK = 1'b0;
  logic            i_RST = 1'b0;
  logic            i_PCEN_n = 1'b0;
  logic            i_SAMPLE_TICK = 1'b0;
  logic [TA_W-1:0] i_TA_VAL = '0;
  logic [TB_W-1:0] i_TB_VAL = '0;
  logic            i_TA_LOAD = 1'b0;
  logic            i_TB_LOAD = 1'b0;
  logic            i_TA_IRQEN = 1'b0;
  logic            i_TB_IRQEN = 1'b0;
  logic            i_TA_FRST = 1'b0;
  logic            i_TB_FRST = 1'b0;
  logic            i_CSM_EN = 1'b0;
  logic [TA_W-1:0] o_TA_CNT;
  logic [TB_W-1:0] o_TB_CNT;
  logic            o_TA_FLAG;
  logic            o_TB_FLAG;
  logic            o_IRQ_n;
  logic            o_CSM_KON;

  logic clk_run = 1'b0;

  ika2151_timer_ctrl #(
    .TA_WIDTH    (TA_W),
    .TB_WIDTH    (TB_W),
    .TB_PRESCALE (PRE)
  ) dut (
    .i_EMUCLK      (i_EMUCLK),
    .i_RST         (i_RST),
    .i_PCEN_n      (i_PCEN_n),
    .i_SAMPLE_TICK (i_SAMPLE_TICK),
    .i_TA_VAL      (i_TA_VAL),
    .i_TB_VAL      (i_TB_VAL),
    .i_TA_LOAD     (i_TA_LOAD),
    .i_TB_LOAD     (i_TB_LOAD),
    .i_TA_IRQEN    (i_TA_IRQEN),
    .i_TB_IRQEN    (i_TB_IRQEN),
    .i_TA_FRST     (i_TA_FRST),
    .i_TB_FRST     (i_TB_FRST),
    .i_CSM_EN      (i_CSM_EN),
    .o_TA_CNT      (o_TA_CNT),
    .o_TB_CNT      (o_TB_CNT),
    .o_TA_FLAG     (o_TA_FLAG),
    .o_TB_FLAG     (o_TB_FLAG),
    .o_IRQ_n       (o_IRQ_n),
    .o_CSM_KON     (o_CSM_KON)
  );

  always begin
    #5;
    if (clk_run) i_EMUCLK = ~i_EMUCLK;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_underflow: observed=%0d expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock, outputs sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge i_EMUCLK);
    #1;
  endtask

  task automatic tick();
    i_SAMPLE_TICK = 1'b1;
    cyc();
    i_SAMPLE_TICK = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset with no clock running.
    #3;
    i_RST = 1'b1;
    #2;
    expect_val("rst_ta_cnt", 0);   check(o_TA_CNT);
    expect_val("rst_tb_cnt", 0);   check(o_TB_CNT);
    expect_val("rst_ta_flag", 0);  check(o_TA_FLAG);
    expect_val("rst_tb_flag", 0);  check(o_TB_FLAG);
    expect_val("rst_irq_n", 1);    check(o_IRQ_n);
    expect_val("rst_csm", 0);      check(o_CSM_KON);
    clk_run = 1'b1;
    idle(2);
    i_RST = 1'b0;
    idle(1);

    // Timer A period: VAL 1020, tick every 4 enable cycles.
    i_TA_VAL = 10'd1020; i_TA_IRQEN = 1'b1; i_TA_LOAD = 1'b1;
    expect_val("ta_preload", 1020);
    cyc();
    check(o_TA_CNT);
    for (int k = 1; k <= 4; k++) begin
      idle(3);
      expect_val("ta_count", (k < 4) ? 1020 + k : 1020);
      tick();
      check(o_TA_CNT);
    end
    expect_val("ta_flag_set", 1);      check(o_TA_FLAG);
    expect_val("ta_irq_lag", 1);       check(o_IRQ_n);
    cyc();
    expect_val("ta_irq_low", 0);       check(o_IRQ_n);
    expect_val("ta_no_csm", 0);        check(o_CSM_KON);
    for (int k = 1; k <= 4; k++) begin
      idle(3);
      tick();
    end
    expect_val("ta_second_period", 1020); check(o_TA_CNT);
    expect_val("ta_flag_kept", 1);        check(o_TA_FLAG);
    // FRST alone clears the flag; IRQ releases one enable cycle later.
    i_TA_FRST = 1'b1;
    cyc();
    i_TA_FRST = 1'b0;
    expect_val("ta_frst_clear", 0);    check(o_TA_FLAG);
    expect_val("ta_frst_irq_lag", 0);  check(o_IRQ_n);
    cyc();
    expect_val("ta_frst_irq_high", 1); check(o_IRQ_n);
    i_TA_LOAD = 1'b0;
    cyc();

    // Timer B period: VAL 254, prescale 16.
    i_TB_VAL = 8'd254; i_TB_IRQEN = 1'b1; i_TB_LOAD = 1'b1;
    expect_val("tb_preload", 254);
    cyc();
    check(o_TB_CNT);
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (t == 15) begin
        expect_val("tb_before_first", 254); check(o_TB_CNT);
      end
      if (t == 16) begin
        expect_val("tb_first_count", 255); check(o_TB_CNT);
      end
      if (t == 31) begin
        expect_val("tb_flag_early", 0); check(o_TB_FLAG);
      end
    end
    expect_val("tb_reload", 254);       check(o_TB_CNT);
    expect_val("tb_flag_set", 1);       check(o_TB_FLAG);
    expect_val("ta_frozen_idle", 1020); check(o_TA_CNT);
    cyc();
    expect_val("tb_irq_low", 0);        check(o_IRQ_n);
    i_TB_FRST = 1'b1;
    cyc();
    i_TB_FRST = 1'b0;
    expect_val("tb_frst_clear", 0);     check(o_TB_FLAG);
    cyc();
    expect_val("tb_irq_high", 1);       check(o_IRQ_n);
    i_TB_LOAD = 1'b0;
    cyc();

    // Flag control on Timer A.
    i_TA_VAL = 10'd1022; i_TA_IRQEN = 1'b0; i_TA_LOAD = 1'b1;
    cyc();
    tick();
    tick();
    expect_val("irqen0_reload", 1022); check(o_TA_CNT);
    expect_val("irqen0_noflag", 0);    check(o_TA_FLAG);
    i_TA_IRQEN = 1'b1;
    tick();
    i_TA_FRST = 1'b1;
    tick();
    i_TA_FRST = 1'b0;
    expect_val("frst_ovf_reload", 1022); check(o_TA_CNT);
    expect_val("frst_beats_set", 0);     check(o_TA_FLAG);
    tick();
    tick();
    expect_val("flag_set_again", 1);   check(o_TA_FLAG);
    i_TA_IRQEN = 1'b0;
    cyc();
    expect_val("irqen_off_keeps", 1);  check(o_TA_FLAG);
    expect_val("irq_low_again", 0);    check(o_IRQ_n);
    i_TA_FRST = 1'b1;
    cyc();
    i_TA_FRST = 1'b0;
    cyc();
    expect_val("irq_released", 1);     check(o_IRQ_n);
    i_TA_LOAD = 1'b0;
    cyc();

    // CSM: VAL 1023, every counted tick overflows. LOAD edge plus tick
    // preloads only.
    i_CSM_EN = 1'b1; i_TA_IRQEN = 1'b0; i_TA_VAL = 10'd1023; i_TA_LOAD = 1'b1;
    tick();
    expect_val("edge_tick_preload", 1023); check(o_TA_CNT);
    expect_val("edge_tick_no_csm", 0);     check(o_CSM_KON);
    for (int k = 1; k <= 3; k++) begin
      tick();
      expect_val("csm_cnt", 1023); check(o_TA_CNT);
      expect_val("csm_pulse", 1);  check(o_CSM_KON);
      cyc();
      expect_val("csm_end", 0);    check(o_CSM_KON);
      cyc();
    end
    expect_val("csm_no_flag", 0); check(o_TA_FLAG);
    // Drop LOAD together with a tick: timer stops, nothing counted.
    i_TA_LOAD = 1'b0;
    tick();
    expect_val("stop_no_csm", 0); check(o_CSM_KON);
    // A running counter would overflow here and reload 1010.
    i_TA_VAL = 10'd1010;
    tick();
    expect_val("stop_frozen", 1023);   check(o_TA_CNT);
    expect_val("stop_no_csm2", 0);     check(o_CSM_KON);
    i_TA_LOAD = 1'b1;
    cyc();
    expect_val("restart_preload", 1010); check(o_TA_CNT);
    i_TA_LOAD = 1'b0; i_CSM_EN = 1'b0;
    cyc();

    // Gating: ticks with i_PCEN_n high are ignored.
    i_TB_VAL = 8'd199; i_TB_LOAD = 1'b1;
    cyc();
    i_PCEN_n = 1'b1;
    i_SAMPLE_TICK = 1'b1;
    idle(20);
    i_SAMPLE_TICK = 1'b0;
    i_PCEN_n = 1'b0;
    expect_val("gated_hold", 199); check(o_TB_CNT);
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 15) begin
        expect_val("gated_pre15", 199); check(o_TB_CNT);
      end
    end
    expect_val("gated_count", 200); check(o_TB_CNT);
    for (int t = 1; t <= 7; t++) tick();

    // Reset mid-count: counter 200, prescaler 7.
    #2;
    i_RST = 1'b1;
    #1;
    expect_val("mid_rst_tb", 0);   check(o_TB_CNT);
    expect_val("mid_rst_ta", 0);   check(o_TA_CNT);
    expect_val("mid_rst_irq", 1);  check(o_IRQ_n);
    idle(2);
    i_RST = 1'b0;
    cyc();
    expect_val("post_rst_reload", 199); check(o_TB_CNT);
    tick();
    expect_val("post_rst_pre_cleared", 199); check(o_TB_CNT);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
